// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture path: FSM encoding and default sizing.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int          DEFAULT_WIDTH         = 32;
    localparam logic [31:0] DEFAULT_TIMEOUT_TICKS = 32'hFFFF_FFFE;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus a previous-sample flop; emits the synchronized
// level and single-cycle rise/fall strobes.
module pwm_edge_sync (
    input  logic aclk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM demodulator: measures rise-to-rise period (minus one) and high time in
// ce ticks, reported in the same encoding the pwm_l1 modulator consumes.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int               WIDTH         = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TIMEOUT_TICKS = WIDTH'(DEFAULT_TIMEOUT_TICKS)
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic             ce,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] comparator,
    output logic             update,
    output logic             valid,
    output logic             stall,
    output logic             stall_level
);

    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_timeout;

    state_t           r_state;
    logic [WIDTH-1:0] r_pcnt;
    logic [WIDTH-1:0] r_hcnt;
    logic             r_high_open;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_comparator;
    logic             r_update;
    logic             r_valid;
    logic             r_stall;
    logic             r_stall_level;

    pwm_edge_sync u_edge_sync (
        .aclk    (aclk),
        .reset   (reset),
        .i_async (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // A rise in the same cycle always takes priority over a timeout.
    assign w_timeout = (r_state != ST_IDLE) && ce && !w_rise &&
                       (r_pcnt == TIMEOUT_TICKS);

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pcnt        <= '0;
            r_hcnt        <= '0;
            r_high_open   <= 1'b0;
            r_period      <= '0;
            r_comparator  <= '0;
            r_update      <= 1'b0;
            r_valid       <= 1'b0;
            r_stall       <= 1'b0;
            r_stall_level <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (w_rise) begin
                r_pcnt      <= '0;
                r_hcnt      <= WIDTH'(ce);
                r_high_open <= 1'b1;
                r_stall     <= 1'b0;
                if (r_state == ST_IDLE) begin
                    r_state <= ST_ARMED;
                end else begin
                    r_period     <= r_pcnt;
                    r_comparator <= r_hcnt;
                    r_update     <= 1'b1;
                    r_valid      <= 1'b1;
                    r_state      <= ST_LOCKED;
                end
            end else begin
                if (ce && (r_pcnt != TIMEOUT_TICKS)) begin
                    r_pcnt <= r_pcnt + WIDTH'(1);
                end
                // High time freezes at the first fall after the rise.
                if (ce && w_level && r_high_open && (r_hcnt != TIMEOUT_TICKS)) begin
                    r_hcnt <= r_hcnt + WIDTH'(1);
                end
                if (w_fall) begin
                    r_high_open <= 1'b0;
                end
                if (w_timeout) begin
                    r_stall       <= 1'b1;
                    r_stall_level <= w_level;
                    r_valid       <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            end
        end
    end

    assign period      = r_period;
    assign comparator  = r_comparator;
    assign update      = r_update;
    assign valid       = r_valid;
    assign stall       = r_stall;
    assign stall_level = r_stall_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: an event-history model predicts every
// output each cycle, and literal expectations pin the key measurements.
module tb_pwm_capture;

    localparam int W    = 16;
    localparam int TO   = 20;
    localparam int MAXE = 4096;

    logic         aclk;
    logic         reset;
    logic         ce;
    logic         pwm_in;
    logic [W-1:0] period;
    logic [W-1:0] comparator;
    logic         update;
    logic         valid;
    logic         stall;
    logic         stall_level;

    int checks = 0;
    int errors = 0;

    pwm_capture #(
        .WIDTH         (W),
        .TIMEOUT_TICKS (W'(TO))
    ) dut (
        .aclk        (aclk),
        .reset       (reset),
        .ce          (ce),
        .pwm_in      (pwm_in),
        .period      (period),
        .comparator  (comparator),
        .update      (update),
        .valid       (valid),
        .stall       (stall),
        .stall_level (stall_level)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of what each edge saw, measurements derived from windows
    // between the edges at which a synchronized rise is recognised.
    bit     m_samp [MAXE];
    bit     m_rst  [MAXE];
    bit     m_ce   [MAXE];
    bit     m_lvl  [MAXE];
    int     m_edge = 0;
    int     m_last_rise = 0;
    int     m_mode = 0;          // rises seen since reset/stall, capped at 2
    bit     model_on = 1'b0;
    longint m_period = 0;
    longint m_comp = 0;
    bit     m_update = 1'b0;
    bit     m_valid = 1'b0;
    bit     m_stall = 1'b0;
    bit     m_stall_level = 1'b0;

    function automatic int ce_ticks(input int from_e, input int to_e);
        int n = 0;
        for (int e = from_e; e < to_e; e++) n += int'(m_ce[e]);
        return (n > TO) ? TO : n;
    endfunction

    function automatic int high_ticks(input int from_e, input int to_e);
        int n = 0;
        for (int e = from_e; e < to_e; e++) n += int'(m_ce[e] && m_lvl[e]);
        return (n > TO) ? TO : n;
    endfunction

    always @(posedge aclk) begin
        int k;
        bit prev_lvl;
        bit rise;
        k = m_edge;
        m_rst[k]  = reset;
        m_ce[k]   = ce;
        m_samp[k] = reset ? 1'b0 : pwm_in;
        // Level seen at edge k is the input two edges earlier, unless reset intervened.
        m_lvl[k]  = (k >= 2 && !m_rst[k-1]) ? m_samp[k-2] : 1'b0;
        prev_lvl  = (k >= 1) ? m_lvl[k-1] : 1'b0;
        rise      = m_lvl[k] && !prev_lvl;
        m_update  = 1'b0;
        if (reset) begin
            m_period = 0; m_comp = 0; m_valid = 0; m_stall = 0; m_stall_level = 0;
            m_mode = 0; model_on = 1'b1;
        end else if (rise) begin
            if (m_mode >= 1) begin
                m_period = ce_ticks(m_last_rise + 1, k);
                m_comp   = high_ticks(m_last_rise, k);
                m_update = 1'b1;
                m_valid  = 1'b1;
                m_mode   = 2;
            end else begin
                m_mode = 1;
            end
            m_stall     = 1'b0;
            m_last_rise = k;
        end else if (m_mode >= 1 && ce && ce_ticks(m_last_rise + 1, k) == TO) begin
            m_stall       = 1'b1;
            m_stall_level = m_lvl[k];
            m_valid       = 1'b0;
            m_mode        = 0;
        end
        m_edge++;
    end

    always @(negedge aclk) begin
        if (model_on) begin
            check("cyc_period",      period,      m_period);
            check("cyc_comparator",  comparator,  m_comp);
            check("cyc_update",      update,      m_update);
            check("cyc_valid",       valid,       m_valid);
            check("cyc_stall",       stall,       m_stall);
            check("cyc_stall_level", stall_level, m_stall_level);
        end
    end

    int     upd_cnt = 0;
    longint mon_period = 0;
    longint mon_comp = 0;

    always @(negedge aclk) begin
        if (update === 1'b1) begin
            upd_cnt++;
            mon_period = period;
            mon_comp   = comparator;
            $display("update period=%0d comparator=%0d at %0t", period, comparator, $time);
        end
    end

    int g_ph = 0;

    task automatic tick(input logic p, input logic c, input logic r);
        pwm_in = p;
        ce     = c;
        reset  = r;
        @(posedge aclk);
        #1;
    endtask

    // Loopback of the modulator: high for cmp ticks out of per+1.
    task automatic gen(input int n, input int per, input int cmp);
        for (int i = 0; i < n; i++) begin
            tick(g_ph < cmp, 1'b1, 1'b0);
            g_ph = (g_ph >= per) ? 0 : g_ph + 1;
        end
    endtask

    initial begin
        int snap;
        pwm_in = 1'b0;
        ce     = 1'b1;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
        check("rst_period",     period,     0);
        check("rst_comparator", comparator, 0);
        check("rst_valid",      valid,      0);
        check("rst_update",     update,     0);

        // Steady loopback 9/3.
        g_ph = 0;
        gen(40, 9, 3);
        check("t1_period",     period,     9);
        check("t1_comparator", comparator, 3);
        check("t1_valid",      valid,      1);
        check("t1_model_per",  m_period,   9);
        check("t1_model_cmp",  m_comp,     3);
        check("t1_updates",    upd_cnt,    3);

        // Duty change at a period boundary.
        gen(30, 9, 7);
        check("t2_period",     period,     9);
        check("t2_comparator", comparator, 7);
        check("t2_model_cmp",  m_comp,     7);

        // Input stuck low.
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'b0);
        check("t3_stall",       stall,       1);
        check("t3_stall_level", stall_level, 0);
        check("t3_valid",       valid,       0);
        check("t3_hold_period", period,      9);
        check("t3_hold_cmp",    comparator,  7);
        g_ph = 0;
        gen(25, 9, 3);
        check("t3_relock_valid", valid,      1);
        check("t3_relock_stall", stall,      0);
        check("t3_relock_per",   period,     9);
        check("t3_relock_cmp",   comparator, 3);

        // Input stuck high (duty beyond period).
        gen(5, 9, 3);
        gen(5, 9, 12);
        snap = upd_cnt;
        gen(35, 9, 12);
        check("t4_no_updates",   upd_cnt - snap, 0);
        check("t4_stall",        stall,          1);
        check("t4_stall_level",  stall_level,    1);
        check("t4_valid",        valid,          0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
        g_ph = 0;
        gen(30, 9, 3);
        check("t4_relock_valid", valid, 1);

        // ce gap of 5 cycles inside one period.
        for (int i = 0; i < 10; i++) tick(i < 3, !(i >= 5), 1'b0);
        g_ph = 0;
        gen(4, 9, 3);
        check("t5_short_period", mon_period, 4);
        check("t5_short_cmp",    mon_comp,   3);
        check("t5_valid",        valid,      1);
        gen(16, 9, 3);
        check("t5_ref_period",   mon_period, 9);

        // Reset in the middle of a locked period.
        gen(5, 9, 3);
        tick(1'b0, 1'b1, 1'b1);
        check("t6_rst_period", period,     0);
        check("t6_rst_cmp",    comparator, 0);
        check("t6_rst_valid",  valid,      0);
        check("t6_rst_stall",  stall,      0);
        check("t6_rst_update", update,     0);
        g_ph = 0;
        snap = upd_cnt;
        gen(12, 9, 3);
        check("t6_no_early_update", upd_cnt - snap, 0);
        gen(3, 9, 3);
        check("t6_first_update", upd_cnt - snap, 1);
        check("t6_period",       mon_period,     9);
        check("t6_cmp",          mon_comp,       3);

        gen(5, 9, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
